// File: rtl/sh_mem_port_pkg.sv
// Shared definitions for the shared-memory core port: bus widths, enable
// encodings, port FSM states and the buffered request record.
package sh_mem_port_pkg;

  // Address layout is {bank id, word address}; the port treats it as opaque.
  localparam int ADDR_SIZE = 8;
  localparam int REG_SIZE  = 8;

  localparam logic [1:0] MEM_EN_IDLE  = 2'b00;
  localparam logic [1:0] MEM_EN_READ  = 2'b01;
  localparam logic [1:0] MEM_EN_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } port_state_t;

  typedef struct packed {
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [REG_SIZE-1:0]  wr_data;
  } port_req_t;

  localparam int REQ_W = $bits(port_req_t);

  // Bus enable code for a buffered request.
  function automatic logic [1:0] mem_enable_for(input logic we);
    return we ? MEM_EN_WRITE : MEM_EN_READ;
  endfunction

endpackage

// File: rtl/sh_mem_port_fifo.sv
// Synchronous request buffer: power-of-two depth, head entry visible
// combinationally, simultaneous push and pop keep the occupancy unchanged.
module sh_mem_port_fifo #(
  parameter int FIFO_DEPTH = 2,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] storage [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = storage[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries data only, so it is written without reset.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sh_mem_port.sv
// One core's port onto the shared-memory buses: buffers core requests,
// presents the oldest one on this core's bus slice until the memory grants
// it, then returns a one-cycle response in request order.
module sh_mem_port
  import sh_mem_port_pkg::*;
#(
  parameter int CORE_ID    = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 core_req_valid,
  input  logic                 core_req_we,
  input  logic [ADDR_SIZE-1:0] core_addr,
  input  logic [REG_SIZE-1:0]  core_wr_data,
  output logic                 core_req_ready,
  output logic                 core_resp_valid,
  output logic [REG_SIZE-1:0]  core_rd_data,
  output logic [1:0]           mem_enable,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [REG_SIZE-1:0]  mem_wr_data,
  input  logic                 mem_ready,
  input  logic [REG_SIZE-1:0]  mem_rd_data
);

  // Reject configurations the pointer arithmetic cannot support.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CORE_ID < 0) begin : g_bad_param
    $error("sh_mem_port: FIFO_DEPTH must be a power of two >= 2 and CORE_ID >= 0");
  end

  port_state_t         state_q;
  port_state_t         state_d;
  port_req_t           push_req;
  port_req_t           head_req;
  logic [REQ_W-1:0]    head_bits;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [REG_SIZE-1:0] rd_data_p1;

  assign push_req = '{we: core_req_we, addr: core_addr, wr_data: core_wr_data};
  assign head_req = port_req_t'(head_bits);

  // Readiness comes from occupancy alone, never from core_req_valid.
  assign core_req_ready = !fifo_full;
  assign push           = core_req_valid && core_req_ready;

  sh_mem_port_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (REQ_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_bits)
  );

  // FSM state register; reset drops any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and head pop; mem_ready only matters while a request is on the bus.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_ready) begin
          pop     = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the granted read word; a granted write responds with zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_p1 <= '0;
    end else if (state_q == ST_REQ && mem_ready) begin
      rd_data_p1 <= head_req.we ? '0 : mem_rd_data;
    end
  end

  // Bus slice is driven purely from registered state and the FIFO head, so
  // it stays constant for the whole grant wait and is idle outside REQ.
  always_comb begin
    mem_enable      = MEM_EN_IDLE;
    mem_addr        = '0;
    mem_wr_data     = '0;
    core_resp_valid = 1'b0;
    core_rd_data    = '0;
    if (state_q == ST_REQ) begin
      mem_enable  = mem_enable_for(head_req.we);
      mem_addr    = head_req.addr;
      mem_wr_data = head_req.wr_data;
    end
    if (state_q == ST_RESP) begin
      core_resp_valid = 1'b1;
      core_rd_data    = rd_data_p1;
    end
  end

endmodule

// File: tb/tb_sh_mem_port.sv
// Bench for sh_mem_port: a behavioural shared memory with programmable grant
// stall answers bus requests; a response scoreboard and a bus-request queue
// are filled as requests are accepted and drained as the DUT produces them.
module tb_sh_mem_port;
  import sh_mem_port_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 core_req_valid;
  logic                 core_req_we;
  logic [ADDR_SIZE-1:0] core_addr;
  logic [REG_SIZE-1:0]  core_wr_data;
  logic                 core_req_ready;
  logic                 core_resp_valid;
  logic [REG_SIZE-1:0]  core_rd_data;
  logic [1:0]           mem_enable;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [REG_SIZE-1:0]  mem_wr_data;
  logic                 mem_ready;
  logic [REG_SIZE-1:0]  mem_rd_data;

  sh_mem_port #(.CORE_ID(0), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .core_req_valid  (core_req_valid),
    .core_req_we     (core_req_we),
    .core_addr       (core_addr),
    .core_wr_data    (core_wr_data),
    .core_req_ready  (core_req_ready),
    .core_resp_valid (core_resp_valid),
    .core_rd_data    (core_rd_data),
    .mem_enable      (mem_enable),
    .mem_addr        (mem_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_ready       (mem_ready),
    .mem_rd_data     (mem_rd_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef logic [2+ADDR_SIZE+REG_SIZE-1:0] bus_t;

  logic [REG_SIZE-1:0] sb_q[$];
  bus_t                bus_q[$];
  logic [REG_SIZE-1:0] shadow    [2**ADDR_SIZE];
  logic [REG_SIZE-1:0] mem_model [2**ADDR_SIZE];

  int   stall    = 0;
  bit   spurious = 1'b0;
  bit   in_req   = 1'b0;
  int   wait_cnt = 0;
  logic [1:0]           prev_en;
  logic [ADDR_SIZE-1:0] prev_addr;
  logic [REG_SIZE-1:0]  prev_wd;

  // Response monitor and shared-memory responder, both on the falling edge.
  initial begin
    mem_ready   = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (core_resp_valid === 1'b1) begin
        if (sb_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else chk("resp_rd_data", 32'(core_rd_data), 32'(sb_q.pop_front()));
      end
      if (mem_enable !== 2'b00) begin
        if (!in_req) begin
          in_req   = 1'b1;
          wait_cnt = 0;
          if (bus_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
          else begin
            bus_t e;
            e = bus_q.pop_front();
            chk("bus_enable", 32'(mem_enable), 32'(e[2+ADDR_SIZE+REG_SIZE-1 -: 2]));
            chk("bus_addr", 32'(mem_addr), 32'(e[ADDR_SIZE+REG_SIZE-1 -: ADDR_SIZE]));
            if (e[2+ADDR_SIZE+REG_SIZE-1 -: 2] == 2'b10)
              chk("bus_wr_data", 32'(mem_wr_data), 32'(e[REG_SIZE-1:0]));
          end
        end else begin
          chk("stall_enable", 32'(mem_enable), 32'(prev_en));
          chk("stall_addr", 32'(mem_addr), 32'(prev_addr));
          chk("stall_wr_data", 32'(mem_wr_data), 32'(prev_wd));
        end
        prev_en   = mem_enable;
        prev_addr = mem_addr;
        prev_wd   = mem_wr_data;
        if (wait_cnt >= stall) begin
          mem_ready = 1'b1;
          if (mem_enable == 2'b10) begin
            mem_model[mem_addr] = mem_wr_data;
            mem_rd_data = 8'h5A;
          end else begin
            mem_rd_data = mem_model[mem_addr];
          end
        end else begin
          mem_ready   = 1'b0;
          mem_rd_data = 8'($urandom);
          wait_cnt++;
        end
      end else begin
        in_req      = 1'b0;
        mem_ready   = spurious;
        mem_rd_data = 8'hEE;
      end
    end
  end

  task automatic send(input logic we, input logic [ADDR_SIZE-1:0] a, input logic [REG_SIZE-1:0] d);
    bit done;
    done = 1'b0;
    @(negedge clk);
    core_req_valid = 1'b1;
    core_req_we    = we;
    core_addr      = a;
    core_wr_data   = d;
    for (int i = 0; i < 200 && !done; i++) begin
      if (core_req_ready === 1'b1) begin
        if (we) begin
          shadow[a] = d;
          sb_q.push_back('0);
          bus_q.push_back({2'b10, a, d});
        end else begin
          sb_q.push_back(shadow[a]);
          bus_q.push_back({2'b01, a, d});
        end
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic release_req();
    @(negedge clk);
    core_req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
    chk({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_idle_after"}, 32'(mem_enable), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**ADDR_SIZE; i++) begin
      shadow[i]    = 8'(i * 7 + 3);
      mem_model[i] = 8'(i * 7 + 3);
    end
    shadow[8'h12]    = 8'hA5;
    mem_model[8'h12] = 8'hA5;

    reset          = 1'b1;
    core_req_valid = 1'b0;
    core_req_we    = 1'b0;
    core_addr      = '0;
    core_wr_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_enable", 32'(mem_enable), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wr_data", 32'(mem_wr_data), 32'd0);
    chk("rst_resp_valid", 32'(core_resp_valid), 32'd0);
    chk("rst_rd_data", 32'(core_rd_data), 32'd0);
    chk("rst_req_ready", 32'(core_req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Single read with grant one cycle into REQ.
    stall = 1;
    send(1'b0, 8'h12, 8'h00);
    release_req();
    drain("single_read");

    // Single write, then read it back.
    stall = 2;
    send(1'b1, 8'h05, 8'h3C);
    release_req();
    drain("single_write");
    send(1'b0, 8'h05, 8'h00);
    release_req();
    drain("write_readback");

    // Long stall: bus slice must hold for every waiting cycle.
    stall = 7;
    send(1'b1, 8'h20, 8'h77);
    release_req();
    drain("stall7");
    repeat (3) @(negedge clk);

    // Three back-to-back requests through a two-entry buffer.
    stall = 4;
    send(1'b0, 8'h30, 8'h00);
    send(1'b1, 8'h31, 8'h99);
    #1;
    chk("full_req_ready", 32'(core_req_ready), 32'd0);
    send(1'b0, 8'h31, 8'h00);
    release_req();
    drain("full_wrap");

    // Mixed traffic with varying grant delay.
    for (int t = 0; t < 12; t++) begin
      stall = $urandom_range(0, 3);
      send(1'(t % 3 == 1), 8'($urandom_range(0, 7)), 8'($urandom));
      if (t % 4 == 3) release_req();
    end
    release_req();
    drain("mixed");

    // Spurious ready while idle and empty, then while a request waits in IDLE.
    stall    = 0;
    spurious = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("spur_resp_valid", 32'(core_resp_valid), 32'd0);
      chk("spur_req_ready", 32'(core_req_ready), 32'd1);
      chk("spur_mem_enable", 32'(mem_enable), 32'd0);
    end
    stall = 2;
    send(1'b0, 8'h12, 8'h00);
    release_req();
    drain("spur_req");
    spurious = 1'b0;

    // Reset while a request is held on the bus.
    stall = 100;
    send(1'b0, 8'h40, 8'h00);
    release_req();
    for (int i = 0; i < 50 && mem_enable == 2'b00; i++) @(negedge clk);
    chk("rst_mid_in_req", 32'(mem_enable), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_mem_enable", 32'(mem_enable), 32'd0);
    chk("rst_mid_resp_valid", 32'(core_resp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(core_req_ready), 32'd1);
    sb_q.delete();
    bus_q.delete();
    @(negedge clk);
    reset = 1'b0;
    stall = 0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_mid_no_resp", 32'(core_resp_valid), 32'd0);
      chk("rst_mid_fifo_empty", 32'(mem_enable), 32'd0);
    end
    send(1'b0, 8'h12, 8'h00);
    release_req();
    drain("after_reset");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
